// File: rtl/l2_cache_control_pkg.sv
// l2_cache_control_pkg: shared types for the L2 cache sequencing FSM
package l2_cache_control_pkg;
  typedef enum logic [2:0] {IDLE, HIT_CHECK, WRITEBACK, ALLOCATE, REFILL} l2_ctrl_state_t;
  localparam int CNT_W_DEFAULT = 32;
endpackage

// File: rtl/l2_cache_control_if.sv
// l2_cache_control_if: upstream request, pmem and datapath strobe bundle
interface l2_cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  logic is_hit;
  logic is_dirty;
  logic is_allocate;
  logic use_replace;
  logic load_data;
  logic load_tag;
  logic load_dirty;
  logic load_valid;
  logic load_plru;
  logic valid_in;
  logic dirty_in;
  modport master (
    input  mem_read, mem_write, pmem_resp, is_hit, is_dirty,
    output mem_resp, pmem_read, pmem_write, is_allocate, use_replace,
           load_data, load_tag, load_dirty, load_valid, load_plru, valid_in, dirty_in
  );
  modport slave (
    output mem_read, mem_write, pmem_resp, is_hit, is_dirty,
    input  mem_resp, pmem_read, pmem_write, is_allocate, use_replace,
           load_data, load_tag, load_dirty, load_valid, load_plru, valid_in, dirty_in
  );
endinterface

// File: rtl/l2_cache_control_perf_counter.sv
// l2_cache_control_perf_counter: wrapping event counter, clear beats increment
module l2_cache_control_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clr ? '0 : inc ? count + CNT_W'(1) : count;
endmodule

// File: rtl/l2_cache_control.sv
// l2_cache_control: hit/writeback/allocate sequencer for the 4-way L2 datapath
module l2_cache_control
  import l2_cache_control_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  l2_cache_control_if.master bus,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);
  l2_ctrl_state_t state, state_n;
  logic refilled;
  logic req, hc, hc_hit, fill, hit_inc, miss_inc, wb_inc;
  assign req = bus.mem_read | bus.mem_write;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = req ? HIT_CHECK : IDLE;
      HIT_CHECK: state_n = (!req || bus.is_hit) ? IDLE : bus.is_dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: state_n = bus.pmem_resp ? ALLOCATE : WRITEBACK;
      ALLOCATE:  state_n = bus.pmem_resp ? REFILL : ALLOCATE;
      REFILL:    state_n = HIT_CHECK;
      default:   state_n = IDLE;
    endcase
  end
  // A write wins when both requests are raised, so mem_write alone selects the write path.
  always_comb begin
    hc              = state == HIT_CHECK && req;
    hc_hit          = hc && bus.is_hit;
    fill            = state == ALLOCATE && bus.pmem_resp;
    hit_inc         = hc_hit && !refilled;
    miss_inc        = hc && !bus.is_hit;
    wb_inc          = state == WRITEBACK && bus.pmem_resp;
    bus.mem_resp    = hc_hit;
    bus.load_plru   = hc_hit;
    bus.load_data   = (hc_hit && bus.mem_write) || fill;
    bus.load_dirty  = (hc_hit && bus.mem_write) || fill;
    bus.dirty_in    = hc_hit && bus.mem_write;
    bus.load_tag    = fill;
    bus.load_valid  = fill;
    bus.valid_in    = fill;
    bus.pmem_write  = state == WRITEBACK;
    bus.pmem_read   = state == ALLOCATE;
    bus.is_allocate = state == ALLOCATE;
    bus.use_replace = state == WRITEBACK || state == ALLOCATE || state == REFILL;
  end
  // refilled suppresses counting the post-refill hit as a second event of the same request.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      refilled <= 1'b0;
    end else begin
      state    <= state_n;
      refilled <= state_n == IDLE ? 1'b0 : fill ? 1'b1 : refilled;
    end
  l2_cache_control_perf_counter #(.CNT_W(CNT_W)) u_hit (
    .clk(clk), .rst(rst), .inc(hit_inc), .clr(perf_clr), .count(hit_count)
  );
  l2_cache_control_perf_counter #(.CNT_W(CNT_W)) u_miss (
    .clk(clk), .rst(rst), .inc(miss_inc), .clr(perf_clr), .count(miss_count)
  );
  l2_cache_control_perf_counter #(.CNT_W(CNT_W)) u_wb (
    .clk(clk), .rst(rst), .inc(wb_inc), .clr(perf_clr), .count(wb_count)
  );
endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: table, hand-sequence and random checks of the L2 sequencer
module tb_l2_cache_control;
  typedef struct {
    logic rd;
    logic wr;
    logic hit;
    logic dirty;
    int   w;
    int   n;
    int   lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic perf_clr = 1'b0;
  logic [31:0] hit_count, miss_count, wb_count;
  l2_cache_control_if bus();
  l2_cache_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .perf_clr(perf_clr),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int hits = 0, misses = 0, wbs = 0;
  logic filled = 1'b0, hit_cfg = 1'b0, dirty_cfg = 1'b0;
  int rw = 0, rn = 0, wcnt = 0, rcnt = 0;
  vec_t vecs[$];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // One clock cycle acting as upstream, datapath and physical memory.
  task automatic tick(input logic rd, input logic wr, input logic clr);
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    perf_clr      = clr;
    bus.is_hit    = hit_cfg | filled;
    bus.is_dirty  = dirty_cfg;
    bus.pmem_resp = 1'b0;
    if (bus.pmem_write) begin
      wcnt++;
      bus.pmem_resp = wcnt == rw;
    end else if (bus.pmem_read) begin
      rcnt++;
      bus.pmem_resp = rcnt == rn;
    end
    #1;
    chk("pmem_exclusive", int'(bus.pmem_read & bus.pmem_write), 0);
    if (bus.pmem_write && bus.pmem_resp) begin
      chk("wb_is_allocate", int'(bus.is_allocate), 0);
      chk("wb_use_replace", int'(bus.use_replace), 1);
    end
    if (bus.pmem_read && bus.pmem_resp) begin
      chk("fill_load_data", int'(bus.load_data), 1);
      chk("fill_load_tag", int'(bus.load_tag), 1);
      chk("fill_load_valid", int'(bus.load_valid), 1);
      chk("fill_valid_in", int'(bus.valid_in), 1);
      chk("fill_load_dirty", int'(bus.load_dirty), 1);
      chk("fill_dirty_in", int'(bus.dirty_in), 0);
      chk("fill_is_allocate", int'(bus.is_allocate), 1);
      filled = 1'b1;
    end
  endtask
  task automatic chk_counters(input string tag);
    chk({tag, "_hit_count"}, int'(hit_count), hits);
    chk({tag, "_miss_count"}, int'(miss_count), misses);
    chk({tag, "_wb_count"}, int'(wb_count), wbs);
  endtask
  task automatic run_txn(input vec_t v, input int exp_lat, input string tag);
    int lat = -1;
    filled = 1'b0; hit_cfg = v.hit; dirty_cfg = v.dirty;
    rw = v.w; rn = v.n; wcnt = 0; rcnt = 0;
    for (int c = 0; c < 300 && lat < 0; c++) begin
      tick(v.rd, v.wr, 1'b0);
      if (bus.mem_resp) begin
        lat = c;
        chk({tag, "_resp_load_data"}, int'(bus.load_data), int'(v.wr));
        chk({tag, "_resp_dirty_in"}, int'(bus.dirty_in), int'(v.wr));
        chk({tag, "_resp_load_dirty"}, int'(bus.load_dirty), int'(v.wr));
        chk({tag, "_resp_load_plru"}, int'(bus.load_plru), 1);
        chk({tag, "_resp_load_tag"}, int'(bus.load_tag), 0);
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    if (v.hit) hits++;
    else begin
      misses++;
      if (v.dirty) wbs++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_wb_cycles"}, wcnt, (!v.hit && v.dirty) ? v.w : 0);
    chk({tag, "_fill_cycles"}, rcnt, !v.hit ? v.n : 0);
    chk_counters(tag);
  endtask
  function automatic int model_lat(input vec_t v);
    return v.hit ? 1 : (v.dirty ? v.w : 0) + v.n + 3;
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t v;
    bus.mem_read = 0; bus.mem_write = 0; bus.pmem_resp = 0;
    bus.is_hit = 0; bus.is_dirty = 0;
    #2;
    chk("rst_mem_resp", int'(bus.mem_resp), 0);
    chk("rst_pmem_read", int'(bus.pmem_read), 0);
    chk("rst_pmem_write", int'(bus.pmem_write), 0);
    chk("rst_use_replace", int'(bus.use_replace), 0);
    chk_counters("rst");
    @(negedge clk);
    rst = 1'b0;
    // rd wr hit dirty w n lat: cold read of set 3, four write fills, then a dirty victim
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 4, 7});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0, 4, 7});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 4});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 5});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 6});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2, 3, 8});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 5});
    foreach (vecs[i]) run_txn(vecs[i], vecs[i].lat, $sformatf("vec%0d", i));
    // Reset while a writeback is outstanding: everything drops immediately.
    filled = 1'b0; hit_cfg = 1'b0; dirty_cfg = 1'b1; rw = 1000; wcnt = 0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("midwb_pmem_write", int'(bus.pmem_write), 1);
    #2 rst = 1'b1;
    #1;
    chk("midwb_rst_pmem_write", int'(bus.pmem_write), 0);
    chk("midwb_rst_use_replace", int'(bus.use_replace), 0);
    hits = 0; misses = 0; wbs = 0;
    chk_counters("midwb_rst");
    bus.mem_read = 1'b0; bus.pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // perf_clr beats a same-cycle hit increment.
    v = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1};
    run_txn(v, 1, "pre_clr");
    filled = 1'b0; hit_cfg = 1'b1; dirty_cfg = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    chk("clr_mem_resp", int'(bus.mem_resp), 1);
    tick(1'b0, 1'b0, 1'b0);
    hits = 0; misses = 0; wbs = 0;
    chk_counters("clr");
    // Read dropped during ALLOCATE: the fill completes, then a silent HIT_CHECK.
    filled = 1'b0; hit_cfg = 1'b0; dirty_cfg = 1'b0; rn = 3; rcnt = 0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("drop_hc_mem_resp", int'(bus.mem_resp), 0);
    for (int c = 2; c <= 4; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk($sformatf("drop_pmem_read_c%0d", c), int'(bus.pmem_read), 1);
    end
    chk("drop_fill_seen", int'(filled), 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("drop_refill_use_replace", int'(bus.use_replace), 1);
    chk("drop_refill_pmem_read", int'(bus.pmem_read), 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("drop_hc2_use_replace", int'(bus.use_replace), 0);
    chk("drop_hc2_mem_resp", int'(bus.mem_resp), 0);
    chk("drop_hc2_load_plru", int'(bus.load_plru), 0);
    chk("drop_hc2_load_data", int'(bus.load_data), 0);
    tick(1'b0, 1'b0, 1'b0);
    misses++;
    chk_counters("drop");
    run_txn(v, 1, "post_drop");
    // Randomized transactions against the latency/counter model.
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 2);
      v.rd    = k != 1;
      v.wr    = k != 0;
      v.hit   = 1'($urandom_range(0, 1));
      v.dirty = 1'($urandom_range(0, 1));
      v.w     = $urandom_range(1, 4);
      v.n     = $urandom_range(1, 5);
      v.lat   = 0;
      run_txn(v, model_lat(v), $sformatf("rnd%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
